vip_csr_bank: RTL



---
 rtl/vip_csr_bank_if.sv | 30 +++
 rtl/vip_csr_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vip_csr_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : vip_csr_bank_if
// Description : Avalon-MM style slave bus bundle for the VIP CSR bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface vip_csr_bank_if #(
    parameter int AV_ADDRESS_WIDTH = 5,
    parameter int AV_DATA_WIDTH    = 32
);
    logic [AV_ADDRESS_WIDTH-1:0]  av_address;
    logic                         av_read;
    logic                         av_write;
    logic [AV_DATA_WIDTH/8-1:0]   av_byteenable;
    logic [AV_DATA_WIDTH-1:0]     av_writedata;
    logic [AV_DATA_WIDTH-1:0]     av_readdata;
    logic                         av_readdatavalid;
    logic                         av_irq;

    modport master (
        output av_address, av_read, av_write, av_byteenable, av_writedata,
        input  av_readdata, av_readdatavalid, av_irq
    );

    modport slave (
        input  av_address, av_read, av_write, av_byteenable, av_writedata,
        output av_readdata, av_readdatavalid, av_irq
    );
endinterface
`default_nettype wire

// File: rtl/vip_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : vip_csr_bank
// Description : Control/status/irq register bank with shadowed user registers
//               committed on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module vip_csr_bank #(
    parameter int AV_ADDRESS_WIDTH     = 5,
    parameter int AV_DATA_WIDTH        = 32,
    parameter int NO_OUTPUTS           = 1,
    parameter int NO_INTERRUPTS        = 2,
    parameter int NO_REGISTERS         = 4,
    parameter int ALLOW_INTERNAL_WRITE = 0,
    parameter int SHADOWED             = 1
) (
    input  wire                                   clk,
    input  wire                                   rst,
    vip_csr_bank_if.slave                         av,
    output logic                                  enable,
    input  wire                                   clear_enable,
    input  wire                                   commit,
    output logic                                  update_pending,
    output logic [NO_REGISTERS-1:0]               triggers,
    output logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers,
    input  wire  [AV_DATA_WIDTH*NO_REGISTERS-1:0] registers_in,
    input  wire  [NO_REGISTERS-1:0]               registers_write,
    input  wire  [NO_INTERRUPTS-1:0]              interrupts,
    input  wire  [NO_OUTPUTS-1:0]                 stopped
);

    localparam int c_nbytes    = AV_DATA_WIDTH / 8;
    localparam int c_addr_ctrl = 0;
    localparam int c_addr_stat = 1;
    localparam int c_addr_irq  = 2;
    localparam int c_user_base = 3;

    logic                       r_enable;
    logic [NO_INTERRUPTS:1]     r_irq_en;
    logic [NO_INTERRUPTS:1]     r_irq_status;
    logic [NO_INTERRUPTS-1:0]   r_int_prev;
    logic                       r_irq;
    logic [AV_DATA_WIDTH-1:0]   r_readdata;
    logic                       r_readdatavalid;
    logic [NO_REGISTERS-1:0]    r_trig;
    logic [NO_REGISTERS-1:0]    r_dirty;
    logic                       r_update_pending;
    logic [AV_DATA_WIDTH-1:0]   r_active  [NO_REGISTERS];
    logic [AV_DATA_WIDTH-1:0]   r_pending [NO_REGISTERS];

    logic [AV_DATA_WIDTH-1:0]   w_be_mask;
    logic [NO_INTERRUPTS:0]     w_ctrl_cur;
    logic [NO_INTERRUPTS:0]     w_ctrl_new;
    logic                       w_wr_ctrl;
    logic                       w_wr_irq;
    logic [NO_INTERRUPTS:1]     w_w1c;
    logic [NO_INTERRUPTS:1]     w_rise;
    logic [NO_INTERRUPTS:1]     w_irq_status_next;
    logic [NO_REGISTERS-1:0]    w_wr_user;
    logic [NO_REGISTERS-1:0]    w_int_wr;
    logic [NO_REGISTERS-1:0]    w_dirty_next;
    logic                       w_commit;
    logic [AV_DATA_WIDTH-1:0]   w_rdata;

    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < c_nbytes; b++) begin
            w_be_mask[8*b +: 8] = {8{av.av_byteenable[b]}};
        end
    end

    assign w_wr_ctrl  = av.av_write && (av.av_address == AV_ADDRESS_WIDTH'(c_addr_ctrl));
    assign w_wr_irq   = av.av_write && (av.av_address == AV_ADDRESS_WIDTH'(c_addr_irq));
    assign w_ctrl_cur = {r_irq_en, r_enable};
    assign w_ctrl_new = (w_ctrl_cur & ~w_be_mask[NO_INTERRUPTS:0])
                      | (av.av_writedata[NO_INTERRUPTS:0] & w_be_mask[NO_INTERRUPTS:0]);

    // New edges are ORed in after the W1C so a simultaneous edge survives the clear
    assign w_w1c  = w_wr_irq ? (av.av_writedata[NO_INTERRUPTS:1] & w_be_mask[NO_INTERRUPTS:1]) : '0;
    assign w_rise = interrupts & ~r_int_prev & r_irq_en;
    assign w_irq_status_next = (r_irq_status & ~w_w1c) | w_rise;

    assign w_commit = commit && r_enable && (|r_dirty);

    always_comb begin
        w_wr_user    = '0;
        w_int_wr     = '0;
        w_dirty_next = '0;
        for (int i = 0; i < NO_REGISTERS; i++) begin
            w_wr_user[i] = av.av_write && (av.av_address == AV_ADDRESS_WIDTH'(c_user_base + i));
            w_int_wr[i]  = (ALLOW_INTERNAL_WRITE != 0) && registers_write[i]
                         && !w_wr_user[i] && !r_dirty[i];
            if (SHADOWED != 0) begin
                w_dirty_next[i] = w_wr_user[i] || (r_dirty[i] && !w_commit);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (av.av_address == AV_ADDRESS_WIDTH'(c_addr_ctrl)) begin
            w_rdata[NO_INTERRUPTS:0] = w_ctrl_cur;
        end else if (av.av_address == AV_ADDRESS_WIDTH'(c_addr_stat)) begin
            w_rdata[0] = &stopped;
            w_rdata[1] = r_update_pending;
        end else if (av.av_address == AV_ADDRESS_WIDTH'(c_addr_irq)) begin
            w_rdata[NO_INTERRUPTS:1] = r_irq_status;
        end else begin
            for (int i = 0; i < NO_REGISTERS; i++) begin
                if (av.av_address == AV_ADDRESS_WIDTH'(c_user_base + i)) begin
                    w_rdata = (SHADOWED != 0) ? r_pending[i] : r_active[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable        <= 1'b0;
            r_irq_en        <= '0;
            r_irq_status    <= '0;
            r_int_prev      <= '0;
            r_irq           <= 1'b0;
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= w_ctrl_new[0];
                r_irq_en <= w_ctrl_new[NO_INTERRUPTS:1];
            end else if (clear_enable) begin
                r_enable <= 1'b0;
            end
            r_irq_status    <= w_irq_status_next;
            r_int_prev      <= interrupts;
            r_irq           <= |r_irq_status;
            r_readdatavalid <= av.av_read;
            if (av.av_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    // Pending always mirrors active when unshadowed, so merging from pending is valid in both modes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig           <= '0;
            r_dirty          <= '0;
            r_update_pending <= 1'b0;
            for (int i = 0; i < NO_REGISTERS; i++) begin
                r_active[i]  <= '0;
                r_pending[i] <= '0;
            end
        end else begin
            r_trig <= '0;
            for (int i = 0; i < NO_REGISTERS; i++) begin
                if (w_wr_user[i]) begin
                    r_pending[i] <= (r_pending[i] & ~w_be_mask) | (av.av_writedata & w_be_mask);
                    if (SHADOWED == 0) begin
                        r_active[i] <= (r_pending[i] & ~w_be_mask) | (av.av_writedata & w_be_mask);
                        r_trig[i]   <= 1'b1;
                    end
                end else if (w_commit && r_dirty[i]) begin
                    r_active[i] <= r_pending[i];
                    r_trig[i]   <= 1'b1;
                end else if (w_int_wr[i]) begin
                    r_active[i]  <= registers_in[AV_DATA_WIDTH*i +: AV_DATA_WIDTH];
                    r_pending[i] <= registers_in[AV_DATA_WIDTH*i +: AV_DATA_WIDTH];
                end
            end
            r_dirty          <= w_dirty_next;
            r_update_pending <= |w_dirty_next;
        end
    end

    generate
        for (genvar g = 0; g < NO_REGISTERS; g++) begin : g_reg_out
            assign registers[AV_DATA_WIDTH*g +: AV_DATA_WIDTH] = r_active[g];
        end
    endgenerate

    assign enable              = r_enable;
    assign update_pending      = r_update_pending;
    assign triggers            = r_trig;
    assign av.av_readdata      = r_readdata;
    assign av.av_readdatavalid = r_readdatavalid;
    assign av.av_irq           = r_irq;

endmodule
`default_nettype wire
